vtpg_mon: RTL and testbench

Receive-side monitor for the video timing/pattern generator interface (hs, vs, rgb_vld, rgb).
- Measures horizontal and vertical timing from the incoming syncs.
- Checks that the pixel stream carries the incrementing grey ramp (R=G=B=cnt, +1 per valid pixel, wrap mod 2^PW).
- Reports per-frame measurements, a lock flag and error counts.
- Sits on the sink side of the video bus in the test/bring-up path.

---
 rtl/vtpg_pkg.sv | 18 +
 rtl/vtpg_pix_chk.sv | 88 ++++++++
 rtl/vtpg_mon.sv | 188 ++++++++++++++++++
 tb/tb_vtpg_mon.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vtpg_pkg.sv
// Shared constants for the video timing/pattern generator interface, so the
// generator and the monitor agree on default widths and the pixel-check
// state encoding.
package vtpg_pkg;

    localparam int H_BITS_DEF   = 12;
    localparam int V_BITS_DEF   = 12;
    localparam int PW_DEF       = 8;
    localparam int ERR_BITS_DEF = 16;

    // Pixel ramp checker state: UNSYNC until the first valid pixel seeds
    // the expected value, SYNC afterwards.
    typedef enum logic {
        UNSYNC = 1'b0,
        SYNC   = 1'b1
    } pix_state_t;

endpackage

// File: rtl/vtpg_pix_chk.sv
// Grey-ramp pixel checker: every valid pixel must carry R=G=B and R must be
// one more (mod 2^PW) than the previous valid pixel. A mismatch pulses
// o_pix_err one cycle later, bumps a saturating counter and resyncs the
// expected value to the received R.
module vtpg_pix_chk
    import vtpg_pkg::*;
#(
    parameter int PW       = PW_DEF,
    parameter int ERR_BITS = ERR_BITS_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_vld,
    input  logic [3*PW-1:0]     i_rgb,
    output logic                o_pix_err,
    output logic [ERR_BITS-1:0] o_err_cnt,
    output pix_state_t          o_state
);

    localparam logic [PW-1:0]       PX_ONE  = PW'(1);
    localparam logic [ERR_BITS-1:0] ERR_ONE = ERR_BITS'(1);

    logic [PW-1:0]       w_r;
    logic [PW-1:0]       w_g;
    logic [PW-1:0]       w_b;
    pix_state_t          r_state;
    pix_state_t          w_state_nxt;
    logic [PW-1:0]       r_exp;
    logic [PW-1:0]       w_exp_nxt;
    logic [ERR_BITS-1:0] r_err_cnt;
    logic [ERR_BITS-1:0] w_err_nxt;
    logic                r_pix_err;
    logic                w_mismatch;

    assign w_r = i_rgb[3*PW-1:2*PW];
    assign w_g = i_rgb[2*PW-1:PW];
    assign w_b = i_rgb[PW-1:0];

    // State, expected value, error pulse and error count registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= UNSYNC;
            r_exp     <= '0;
            r_err_cnt <= '0;
            r_pix_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_exp     <= w_exp_nxt;
            r_err_cnt <= w_err_nxt;
            r_pix_err <= w_mismatch;
        end
    end

    // Next-state logic; blanking cycles (i_vld low) leave everything as is.
    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_err_nxt   = r_err_cnt;
        w_mismatch  = 1'b0;
        case (r_state)
            UNSYNC: begin
                if (i_vld) begin
                    w_exp_nxt   = w_r + PX_ONE;
                    w_state_nxt = SYNC;
                end
            end
            SYNC: begin
                if (i_vld) begin
                    if ((w_r != r_exp) || (w_g != w_r) || (w_b != w_r)) begin
                        w_mismatch = 1'b1;
                        w_exp_nxt  = w_r + PX_ONE;
                        if (r_err_cnt != '1) begin
                            w_err_nxt = r_err_cnt + ERR_ONE;
                        end
                    end else begin
                        w_exp_nxt = r_exp + PX_ONE;
                    end
                end
            end
            default: w_state_nxt = UNSYNC;
        endcase
    end

    assign o_pix_err = r_pix_err;
    assign o_err_cnt = r_err_cnt;
    assign o_state   = r_state;

endmodule

// File: rtl/vtpg_mon.sv
// Receive-side monitor for the video timing/pattern generator bus. Measures
// horizontal/vertical timing from the syncs, reports it once per frame,
// flags lock when two consecutive frames measure identically, and checks
// the grey-ramp pixel content.
// Bus semantics: rgb_vld qualifies rgb in the cycle it is high; there is no
// backpressure, the sink must accept every valid pixel.
module vtpg_mon
    import vtpg_pkg::*;
#(
    parameter int H_BITS   = H_BITS_DEF,
    parameter int V_BITS   = V_BITS_DEF,
    parameter int PW       = PW_DEF,
    parameter int ERR_BITS = ERR_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hs,
    input  logic                vs,
    input  logic                rgb_vld,
    input  logic [3*PW-1:0]     rgb,
    output logic [H_BITS-1:0]   h_total,
    output logic [H_BITS-1:0]   hs_width,
    output logic [H_BITS-1:0]   hact_width,
    output logic [V_BITS-1:0]   v_total,
    output logic [V_BITS-1:0]   vs_width,
    output logic [V_BITS-1:0]   vact_lines,
    output logic                meas_vld,
    output logic                locked,
    output logic                pix_err,
    output logic [ERR_BITS-1:0] err_cnt,
    output pix_state_t          dbg_pix_state
);

    localparam logic [H_BITS-1:0] H_ONE  = H_BITS'(1);
    localparam logic [V_BITS-1:0] V_ONE  = V_BITS'(1);
    localparam int                MEAS_W = 3 * H_BITS + 3 * V_BITS;

    logic              r_hs_q, r_vs_q, r_vld_q;
    logic              w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall, w_vld_fall;
    logic [H_BITS-1:0] r_h_pos, r_h_total, r_hs_width, r_px, r_hact_width;
    logic              r_hs_seen, r_line_act;
    logic [V_BITS-1:0] r_v_pos, r_vact, r_v_total, r_vs_width, r_vact_lines;
    logic              r_vs_seen, r_meas_vld, r_locked, r_snap_vld;
    logic [MEAS_W-1:0] w_meas, r_snap;

    assign w_hs_rise  = hs & ~r_hs_q;
    assign w_hs_fall  = ~hs & r_hs_q;
    assign w_vs_rise  = vs & ~r_vs_q;
    assign w_vs_fall  = ~vs & r_vs_q;
    assign w_vld_fall = ~rgb_vld & r_vld_q;

    // Registered copies of the inputs for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hs_q  <= 1'b0;
            r_vs_q  <= 1'b0;
            r_vld_q <= 1'b0;
        end else begin
            r_hs_q  <= hs;
            r_vs_q  <= vs;
            r_vld_q <= rgb_vld;
        end
    end

    // Horizontal position; line length latched on every hs rise but the first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_pos    <= '0;
            r_h_total  <= '0;
            r_hs_width <= '0;
            r_hs_seen  <= 1'b0;
        end else begin
            if (w_hs_rise) begin
                r_h_pos   <= H_ONE;
                r_hs_seen <= 1'b1;
                if (r_hs_seen) begin
                    r_h_total <= r_h_pos;
                end
            end else if (r_h_pos != '1) begin
                r_h_pos <= r_h_pos + H_ONE;
            end
            if (w_hs_fall) begin
                r_hs_width <= r_h_pos;
            end
        end
    end

    // Valid pixels per line and line activity. The vld fall is seen one
    // cycle after the last pixel, so r_px already includes that pixel.
    // A pixel coinciding with an hs rise belongs to the new line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_px         <= '0;
            r_hact_width <= '0;
            r_line_act   <= 1'b0;
        end else begin
            if (w_hs_rise) begin
                r_px <= rgb_vld ? H_ONE : '0;
            end else if (rgb_vld && (r_px != '1)) begin
                r_px <= r_px + H_ONE;
            end
            if (w_vld_fall) begin
                r_hact_width <= r_px;
            end
            if (rgb_vld) begin
                r_line_act <= 1'b1;
            end else if (w_hs_rise) begin
                r_line_act <= 1'b0;
            end
        end
    end

    // Vertical position in lines, active-line count and per-frame report.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v_pos      <= '0;
            r_vact       <= '0;
            r_v_total    <= '0;
            r_vs_width   <= '0;
            r_vact_lines <= '0;
            r_vs_seen    <= 1'b0;
            r_meas_vld   <= 1'b0;
        end else begin
            r_meas_vld <= 1'b0;
            if (w_vs_rise) begin
                r_v_pos   <= V_ONE;
                r_vact    <= '0;
                r_vs_seen <= 1'b1;
                if (r_vs_seen) begin
                    r_v_total    <= r_v_pos;
                    r_vact_lines <= r_vact + {{(V_BITS-1){1'b0}}, r_line_act};
                    r_meas_vld   <= 1'b1;
                end
            end else if (w_hs_rise) begin
                if (r_v_pos != '1) begin
                    r_v_pos <= r_v_pos + V_ONE;
                end
                if (r_line_act && (r_vact != '1)) begin
                    r_vact <= r_vact + V_ONE;
                end
            end
            if (w_vs_fall) begin
                r_vs_width <= r_v_pos;
            end
        end
    end

    assign w_meas = {r_h_total, r_hs_width, r_hact_width,
                     r_v_total, r_vs_width, r_vact_lines};

    // Lock: compare each fresh frame report with the previous one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_snap     <= '0;
            r_snap_vld <= 1'b0;
            r_locked   <= 1'b0;
        end else if (r_meas_vld) begin
            r_snap     <= w_meas;
            r_snap_vld <= 1'b1;
            if (r_snap_vld) begin
                r_locked <= (w_meas == r_snap);
            end
        end
    end

    vtpg_pix_chk #(
        .PW       (PW),
        .ERR_BITS (ERR_BITS)
    ) u_pix_chk (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_vld     (rgb_vld),
        .i_rgb     (rgb),
        .o_pix_err (pix_err),
        .o_err_cnt (err_cnt),
        .o_state   (dbg_pix_state)
    );

    assign h_total    = r_h_total;
    assign hs_width   = r_hs_width;
    assign hact_width = r_hact_width;
    assign v_total    = r_v_total;
    assign vs_width   = r_vs_width;
    assign vact_lines = r_vact_lines;
    assign meas_vld   = r_meas_vld;
    assign locked     = r_locked;

endmodule

// File: tb/tb_vtpg_mon.sv
// Directed bench for vtpg_mon: a 20-clock x 10-line video generator with a
// grey ramp, checked against hand-computed timing and error values.
module tb_vtpg_mon;
    import vtpg_pkg::*;

    localparam int H_BITS = 12;
    localparam int V_BITS = 12;
    localparam int PW     = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n   = 1'b0;
    logic          hs      = 1'b0;
    logic          vs      = 1'b0;
    logic          rgb_vld = 1'b0;
    logic [3*PW-1:0] rgb   = '0;

    logic [H_BITS-1:0] h_total, hs_width, hact_width;
    logic [V_BITS-1:0] v_total, vs_width, vact_lines;
    logic              meas_vld, locked, pix_err;
    logic [15:0]       err_cnt;
    pix_state_t        dbg_pix_state;

    logic [H_BITS-1:0] h4_total, h4_hs_width, h4_hact_width;
    logic [V_BITS-1:0] v4_total, v4_vs_width, v4_vact_lines;
    logic              m4_meas_vld, m4_locked, m4_pix_err;
    logic [3:0]        err4_cnt;
    pix_state_t        dbg4_pix_state;

    vtpg_mon #(.H_BITS(H_BITS), .V_BITS(V_BITS), .PW(PW), .ERR_BITS(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .rgb_vld(rgb_vld), .rgb(rgb),
        .h_total(h_total), .hs_width(hs_width), .hact_width(hact_width),
        .v_total(v_total), .vs_width(vs_width), .vact_lines(vact_lines),
        .meas_vld(meas_vld), .locked(locked), .pix_err(pix_err),
        .err_cnt(err_cnt), .dbg_pix_state(dbg_pix_state)
    );

    // Narrow error counter instance to reach saturation quickly.
    vtpg_mon #(.H_BITS(H_BITS), .V_BITS(V_BITS), .PW(PW), .ERR_BITS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .rgb_vld(rgb_vld), .rgb(rgb),
        .h_total(h4_total), .hs_width(h4_hs_width), .hact_width(h4_hact_width),
        .v_total(v4_total), .vs_width(v4_vs_width), .vact_lines(v4_vact_lines),
        .meas_vld(m4_meas_vld), .locked(m4_locked), .pix_err(m4_pix_err),
        .err_cnt(err4_cnt), .dbg_pix_state(dbg4_pix_state)
    );

    // ---------------- bookkeeping / monitors ----------------
    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc_n  = 0;
    int n_meas = 0;
    int n_pixerr = 0;
    int last_err_cyc = -1;
    int bad_cyc = -1;
    int bad_lo = 1;
    int bad_hi = 0;
    int pix_idx = 0;
    logic [PW-1:0] pix = '0;
    logic rst_req = 1'b0;
    int m0, e0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (meas_vld === 1'b1) n_meas++;
        if (pix_err === 1'b1) begin
            n_pixerr++;
            last_err_cyc = cyc_n;
        end
    end

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One generator cycle at line v, column h (20 clocks/line, 10 lines/frame).
    task automatic gen_cycle(input int v, input int h, input int hs_w);
        @(posedge clk);
        #1;
        rst_n = rst_req;
        hs    = (h >= 2) && (h < 2 + hs_w);
        vs    = ((v == 1) && (h >= 2)) || ((v == 2) && (h < 2));
        if ((v >= 3) && (v <= 7) && (h >= 6) && (h <= 15)) begin
            rgb_vld = 1'b1;
            if ((pix_idx >= bad_lo) && (pix_idx <= bad_hi)) begin
                rgb     = {pix, pix ^ 8'h01, pix};
                bad_cyc = cyc_n;
            end else begin
                rgb = {pix, pix, pix};
            end
            pix++;
            pix_idx++;
        end else begin
            rgb_vld = 1'b0;
            rgb     = '0;
        end
    endtask

    task automatic run_frames(input int n, input int hs_w);
        for (int f = 0; f < n; f++)
            for (int v = 0; v < 10; v++)
                for (int h = 0; h < 20; h++)
                    gen_cycle(v, h, hs_w);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".h_total"},    h_total,    0);
        check({tag, ".hs_width"},   hs_width,   0);
        check({tag, ".hact_width"}, hact_width, 0);
        check({tag, ".v_total"},    v_total,    0);
        check({tag, ".vs_width"},   vs_width,   0);
        check({tag, ".vact_lines"}, vact_lines, 0);
        check({tag, ".meas_vld"},   meas_vld,   0);
        check({tag, ".locked"},     locked,     0);
        check({tag, ".pix_err"},    pix_err,    0);
        check({tag, ".err_cnt"},    err_cnt,    0);
        check({tag, ".state"},      dbg_pix_state, UNSYNC);
    endtask

    task automatic check_meas(input string tag, input int hs_w_exp);
        check({tag, ".h_total"},    h_total,    20);
        check({tag, ".hs_width"},   hs_width,   hs_w_exp);
        check({tag, ".hact_width"}, hact_width, 10);
        check({tag, ".v_total"},    v_total,    10);
        check({tag, ".vs_width"},   vs_width,   1);
        check({tag, ".vact_lines"}, vact_lines, 5);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_req = 1'b1;

        // Timing measurement and lock over three frames
        run_frames(2, 3);
        @(negedge clk);
        check("t1.meas_after2", n_meas, 1);
        check("t1.locked_after2", locked, 0);
        run_frames(1, 3);
        @(negedge clk);
        check("t1.meas_after3", n_meas, 2);
        check("t1.locked_after3", locked, 1);
        check_meas("t1", 3);
        check("t1.state", dbg_pix_state, SYNC);

        // Clean ramp well past the 255->0 wrap (150 + 200 pixels)
        run_frames(4, 3);
        @(negedge clk);
        check("t2.err_cnt", err_cnt, 0);
        check("t2.err4_cnt", err4_cnt, 0);
        check("t2.pix_err_seen", n_pixerr, 0);
        check("t2.meas", n_meas, 6);
        check("t2.locked", locked, 1);

        // One corrupted pixel: error one cycle later, then resync
        last_err_cyc = -1;
        bad_lo = pix_idx + 12;
        bad_hi = pix_idx + 12;
        run_frames(1, 3);
        @(negedge clk);
        bad_lo = 1;
        bad_hi = 0;
        check("t3.err_cyc", last_err_cyc, bad_cyc + 1);
        check("t3.pix_err_seen", n_pixerr, 1);
        check("t3.err_cnt", err_cnt, 1);
        check("t3.locked", locked, 1);

        // hs width change: one unlocked frame, then relock
        run_frames(1, 4);
        @(negedge clk);
        check("t4.locked_after_change", locked, 0);
        check("t4.hs_width", hs_width, 4);
        run_frames(1, 4);
        @(negedge clk);
        check("t4.locked_relock", locked, 1);

        // Reset pulse mid-line
        for (int v = 0; v < 4; v++)
            for (int h = 0; h < 20; h++)
                gen_cycle(v, h, 4);
        for (int h = 0; h < 10; h++) gen_cycle(4, h, 4);
        rst_req = 1'b0;
        gen_cycle(4, 10, 4);
        rst_req = 1'b1;
        gen_cycle(4, 11, 4);
        @(negedge clk);
        check_all_zero("t5.reset");
        for (int h = 12; h < 20; h++) gen_cycle(4, h, 4);
        for (int v = 5; v < 10; v++)
            for (int h = 0; h < 20; h++)
                gen_cycle(v, h, 4);
        m0 = n_meas;
        run_frames(1, 4);
        @(negedge clk);
        check("t5.first_vs_no_meas", n_meas, m0);
        run_frames(1, 4);
        @(negedge clk);
        check("t5.second_vs_meas", n_meas, m0 + 1);
        check("t5.locked", locked, 0);
        check_meas("t5", 4);
        check("t5.err_cnt", err_cnt, 0);

        // 20 bad pixels: wide counter reaches 20, 4-bit counter holds at 15
        e0 = n_pixerr;
        bad_lo = pix_idx + 3;
        bad_hi = pix_idx + 22;
        run_frames(1, 4);
        @(negedge clk);
        bad_lo = 1;
        bad_hi = 0;
        check("t6.err_cnt", err_cnt, 20);
        check("t6.err4_sat", err4_cnt, 15);
        check("t6.pix_err_cycles", n_pixerr - e0, 20);
        check("t6.locked", locked, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
